// File: rtl/gigatron_vga_out.sv
// gigatron_vga_out: two-stage VGA output stage for the Gigatron core.
// Stage 1 samples colour/syncs and tracks the pixel and line position.
// Stage 2 expands colour, inverts syncs, generates DE and measures line length.
module gigatron_vga_out #(
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 8,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic                clk_vid,
  input  logic                reset,
  input  logic                ce_pix,
  input  logic                de_mode,
  input  logic [IN_BITS-1:0]  red_in,
  input  logic [IN_BITS-1:0]  green_in,
  input  logic [IN_BITS-1:0]  blue_in,
  input  logic                hsync_n,
  input  logic                vsync_n,
  output logic [OUT_BITS-1:0] VGA_R,
  output logic [OUT_BITS-1:0] VGA_G,
  output logic [OUT_BITS-1:0] VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_DE,
  output logic [11:0]         h_total,
  output logic                locked
);

  localparam logic [11:0] IDX_MAX = 12'hFFF;
  localparam logic [12:0] H_LO    = 13'(H_START);
  localparam logic [12:0] H_HI    = 13'(H_START + H_ACTIVE);
  localparam logic [12:0] V_LO    = 13'(V_START);
  localparam logic [12:0] V_HI    = 13'(V_START + V_ACTIVE);

  // Position counters stick at the top value so a missing sync never wraps
  // back into the active window.
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    logic [11:0] r;
    if (v == IDX_MAX) begin
      r = IDX_MAX;
    end else begin
      r = v + 12'd1;
    end
    return r;
  endfunction

  // Stage 1 state
  logic [IN_BITS-1:0] red1_q, red1_d;
  logic [IN_BITS-1:0] green1_q, green1_d;
  logic [IN_BITS-1:0] blue1_q, blue1_d;
  logic               hs1_q, hs1_d;         // stage-1 hsync_n
  logic               vs1_q, vs1_d;         // stage-1 vsync_n
  logic               hedge1_q, hedge1_d;   // stage-1 pixel is an hsync falling edge
  logic [11:0]        h_idx_q, h_idx_d;
  logic [11:0]        v_idx_q, v_idx_d;
  logic               vs_at_edge_q, vs_at_edge_d; // vsync_n seen at the last hsync edge
  logic [11:0]        line_len_q, line_len_d;     // length of the line that just ended

  // Stage 2 state
  logic [OUT_BITS-1:0] r_q, r_d;
  logic [OUT_BITS-1:0] g_q, g_d;
  logic [OUT_BITS-1:0] b_q, b_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                de_q, de_d;
  logic [11:0]         h_total_q, h_total_d;
  logic                locked_q, locked_d;

  logic                hedge_s;
  logic                active_s;
  logic [OUT_BITS-1:0] exp_r_s, exp_g_s, exp_b_s;

  // MSB-first bit replication; source indices are elaboration-time constants.
  for (genvar i = 0; i < OUT_BITS; i++) begin : g_expand
    localparam int SRC = IN_BITS - 1 - ((OUT_BITS - 1 - i) % IN_BITS);
    assign exp_r_s[i] = red1_q[SRC];
    assign exp_g_s[i] = green1_q[SRC];
    assign exp_b_s[i] = blue1_q[SRC];
  end

  assign hedge_s  = ~hsync_n & hs1_q;
  assign active_s = ({1'b0, h_idx_q} >= H_LO) && ({1'b0, h_idx_q} < H_HI) &&
                    ({1'b0, v_idx_q} >= V_LO) && ({1'b0, v_idx_q} < V_HI);

  // Next-state logic for both pipeline stages; everything holds without ce_pix.
  always_comb begin
    red1_d       = red1_q;
    green1_d     = green1_q;
    blue1_d      = blue1_q;
    hs1_d        = hs1_q;
    vs1_d        = vs1_q;
    hedge1_d     = hedge1_q;
    h_idx_d      = h_idx_q;
    v_idx_d      = v_idx_q;
    vs_at_edge_d = vs_at_edge_q;
    line_len_d   = line_len_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    de_d         = de_q;
    h_total_d    = h_total_q;
    locked_d     = locked_q;
    if (ce_pix) begin
      // stage 1: sample inputs and advance the position counters
      red1_d   = red_in;
      green1_d = green_in;
      blue1_d  = blue_in;
      hs1_d    = hsync_n;
      vs1_d    = vsync_n;
      hedge1_d = hedge_s;
      if (hedge_s) begin
        h_idx_d      = 12'd0;
        line_len_d   = sat_inc(h_idx_q);
        vs_at_edge_d = vsync_n;
        if (~vsync_n & vs_at_edge_q) begin
          v_idx_d = 12'd0;
        end else begin
          v_idx_d = sat_inc(v_idx_q);
        end
      end else begin
        h_idx_d = sat_inc(h_idx_q);
      end
      // stage 2: outputs for the pixel currently held in stage 1
      hs_d = ~hs1_q;
      vs_d = ~vs1_q;
      if (de_mode) begin
        de_d = active_s;
        if (active_s) begin
          r_d = exp_r_s;
          g_d = exp_g_s;
          b_d = exp_b_s;
        end else begin
          r_d = {OUT_BITS{1'b0}};
          g_d = {OUT_BITS{1'b0}};
          b_d = {OUT_BITS{1'b0}};
        end
      end else begin
        de_d = hs1_q & vs1_q;
        r_d  = exp_r_s;
        g_d  = exp_g_s;
        b_d  = exp_b_s;
      end
      // line measurement lands together with the h_idx=0 pixel; a saturated
      // measurement never counts towards lock
      if (hedge1_q) begin
        h_total_d = line_len_q;
        locked_d  = (line_len_q == h_total_q) && (h_total_q != 12'd0) &&
                    (line_len_q != IDX_MAX);
      end else if (h_idx_q == IDX_MAX) begin
        locked_d = 1'b0;
      end else begin
        locked_d = locked_q;
      end
    end else begin
      hedge1_d = hedge1_q;
    end
  end

  // Pipeline registers with synchronous reset to the idle, no-sync state.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      red1_q       <= {IN_BITS{1'b0}};
      green1_q     <= {IN_BITS{1'b0}};
      blue1_q      <= {IN_BITS{1'b0}};
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      hedge1_q     <= 1'b0;
      h_idx_q      <= IDX_MAX;
      v_idx_q      <= IDX_MAX;
      vs_at_edge_q <= 1'b1;
      line_len_q   <= 12'd0;
      r_q          <= {OUT_BITS{1'b0}};
      g_q          <= {OUT_BITS{1'b0}};
      b_q          <= {OUT_BITS{1'b0}};
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      h_total_q    <= 12'd0;
      locked_q     <= 1'b0;
    end else begin
      red1_q       <= red1_d;
      green1_q     <= green1_d;
      blue1_q      <= blue1_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      hedge1_q     <= hedge1_d;
      h_idx_q      <= h_idx_d;
      v_idx_q      <= v_idx_d;
      vs_at_edge_q <= vs_at_edge_d;
      line_len_q   <= line_len_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      de_q         <= de_d;
      h_total_q    <= h_total_d;
      locked_q     <= locked_d;
    end
  end

  assign VGA_R   = r_q;
  assign VGA_G   = g_q;
  assign VGA_B   = b_q;
  assign VGA_HS  = hs_q;
  assign VGA_VS  = vs_q;
  assign VGA_DE  = de_q;
  assign h_total = h_total_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_gigatron_vga_out.sv
// Directed bench for gigatron_vga_out with default parameters (2 -> 8 bits).
module tb_gigatron_vga_out;

  logic       clk_vid = 1'b0;
  logic       reset;
  logic       ce_pix;
  logic       de_mode;
  logic [1:0] red_in, green_in, blue_in;
  logic       hsync_n, vsync_n;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_DE;
  logic [11:0] h_total;
  logic       locked;

  int checks = 0;
  int errors = 0;
  int ce_div = 1;
  int hs_cnt = 0;
  int de_cnt = 0;
  logic [31:0] sig = 32'd0;
  logic [31:0] sig_ref;
  logic [26:0] pend_exp;
  logic        pend_valid = 1'b0;
  logic [26:0] out_vec;

  always #5 clk_vid = ~clk_vid;

  gigatron_vga_out dut (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .de_mode(de_mode),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync_n(hsync_n), .vsync_n(vsync_n),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
    .h_total(h_total), .locked(locked)
  );

  assign out_vec = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE};

  function automatic logic [7:0] x4(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One pixel strobe, with ce_div-1 idle clocks before it where nothing may move.
  task automatic strobe();
    logic [39:0] snap;
    for (int k = 1; k < ce_div; k++) begin
      snap = {locked, h_total, out_vec};
      ce_pix = 1'b0;
      @(posedge clk_vid); #1;
      chk("hold", 64'({locked, h_total, out_vec}), 64'(snap));
    end
    ce_pix = 1'b1;
    @(posedge clk_vid); #1;
    ce_pix = 1'b0;
  endtask

  // Drive one pixel; check the outputs for the previous pixel.
  task automatic pix(input logic [1:0] r, input logic [1:0] g, input logic [1:0] b,
                     input logic hs_n, input logic vs_n, input logic act);
    logic [7:0] er, eg, eb;
    logic       ede;
    red_in = r; green_in = g; blue_in = b; hsync_n = hs_n; vsync_n = vs_n;
    strobe();
    if (pend_valid) chk("pixel", 64'(out_vec), 64'(pend_exp));
    sig    = (sig * 32'd33) ^ 32'(out_vec);
    hs_cnt = hs_cnt + int'(VGA_HS);
    de_cnt = de_cnt + int'(VGA_DE);
    if (de_mode) begin
      ede = act;
      er  = act ? x4(r) : 8'h00;
      eg  = act ? x4(g) : 8'h00;
      eb  = act ? x4(b) : 8'h00;
    end else begin
      ede = hs_n & vs_n;
      er  = x4(r);
      eg  = x4(g);
      eb  = x4(b);
    end
    pend_exp   = {er, eg, eb, ~hs_n, ~vs_n, ede};
    pend_valid = 1'b1;
  endtask

  // Pixels x0..x1-1 of line y; hsync low for x < hs_w.
  task automatic line(input int y, input int x0, input int x1, input int hs_w,
                      input logic vs_low, input logic vvalid);
    logic act;
    for (int x = x0; x < x1; x++) begin
      act = vvalid && (x >= 144) && (x < 784) && (y >= 35) && (y < 515);
      pix(2'(x), 2'(y), 2'(x >> 2), logic'(x >= hs_w), ~vs_low, act);
    end
  endtask

  // Only lines around the top and bottom of the active window are full length.
  function automatic int line_len(input int y);
    return ((y == 34) || (y == 35) || (y == 514) || (y == 515)) ? 800 : 10;
  endfunction

  task automatic frame();
    int len;
    de_cnt = 0;
    for (int y = 0; y < 525; y++) begin
      len = line_len(y);
      line(y, 0, len, (len == 800) ? 96 : 2, logic'(y < 2), 1'b1);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    ce_pix = 1'b0;
    @(posedge clk_vid); #1;
    reset      = 1'b0;
    pend_exp   = {24'h000000, 1'b0, 1'b0, ~de_mode};
    pend_valid = 1'b1;
    sig        = 32'd0;
    hs_cnt     = 0;
    de_cnt     = 0;
  endtask

  initial begin
    int len;
    reset = 1'b1; ce_pix = 1'b1; de_mode = 1'b0;
    red_in = 2'b11; green_in = 2'b11; blue_in = 2'b11;
    hsync_n = 1'b1; vsync_n = 1'b1;
    repeat (2) @(posedge clk_vid);
    #1;
    chk("reset_out", 64'(out_vec), 64'd0);
    chk("reset_htotal", 64'(h_total), 64'd0);
    chk("reset_locked", 64'(locked), 64'd0);

    // colour expansion in legacy mode
    do_reset();
    pix(2'b10, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0);
    pix(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("exp_r", 64'(VGA_R), 64'h00000000000000AA);
    chk("exp_g", 64'(VGA_G), 64'h0000000000000055);
    chk("exp_b", 64'(VGA_B), 64'h00000000000000FF);
    chk("exp_de", 64'(VGA_DE), 64'd1);

    // line lock and legacy sync width
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      len = (k < 10) ? 800 : 801;
      if (k == 1) hs_cnt = 0;
      line(k, 0, 2, 96, 1'b0, 1'b0);
      chk("h_total", 64'(h_total), (k == 0) ? 64'd4095 : ((k <= 10) ? 64'd800 : 64'd801));
      chk("locked", 64'(locked), ((k >= 2 && k <= 10) || k == 12) ? 64'd1 : 64'd0);
      if (k < 12) line(k, 2, len, 96, 1'b0, 1'b0);
      if (k == 1) chk("hs_width", 64'(hs_cnt), 64'd96);
    end

    // DE regeneration, full-rate strobe
    de_mode = 1'b1;
    ce_div  = 1;
    do_reset();
    frame();
    chk("de_count_ce1", 64'(de_cnt), 64'd1280);
    sig_ref = sig;

    // same frame with a strobe every 4th clock
    ce_div = 4;
    do_reset();
    frame();
    chk("de_count_ce4", 64'(de_cnt), 64'd1280);
    chk("ce4_same_as_ce1", 64'(sig), 64'(sig_ref));

    // reset in the middle of an active line
    ce_div = 1;
    do_reset();
    for (int y = 0; y < 35; y++) begin
      len = line_len(y);
      line(y, 0, len, (len == 800) ? 96 : 2, logic'(y < 2), 1'b1);
    end
    line(35, 0, 301, 96, 1'b0, 1'b1);
    chk("pre_reset_de", 64'(VGA_DE), 64'd1);
    chk("pre_reset_htotal", 64'(h_total), 64'd800);
    do_reset();
    chk("mid_reset_out", 64'(out_vec), 64'd0);
    chk("mid_reset_htotal", 64'(h_total), 64'd0);
    chk("mid_reset_locked", 64'(locked), 64'd0);
    line(35, 301, 800, 96, 1'b0, 1'b0);
    line(36, 0, 800, 96, 1'b0, 1'b0);
    line(37, 0, 800, 96, 1'b0, 1'b0);
    chk("no_de_before_vsync", 64'(de_cnt), 64'd0);
    frame();
    chk("de_count_after_reset", 64'(de_cnt), 64'd1280);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
